// File: rtl/pipeline_debug_unit_pkg.sv
// -----------------------------------------------------------------------------
// pipeline_debug_unit_pkg
//   Shared constants and types for the UART debug sequencer of the 5-stage
//   MIPS pipeline: link/word widths, command bytes, load terminator, dump
//   length, FSM state encoding and the dump-index -> debug-address mapping.
//   No ports (package).
// -----------------------------------------------------------------------------
package pipeline_debug_unit_pkg;

   localparam int DATA_SZ = 8;    // UART byte width
   localparam int INST_SZ = 32;   // instruction / data word width
   localparam int REG_SZ  = 5;    // debug address width (regs and data memory)
   localparam int MEM_SZ  = 10;   // log2 of IF instruction-memory depth

   localparam logic [INST_SZ-1:0] HALT_INST = 32'hFFFF_FFFF;

   localparam logic [DATA_SZ-1:0] CMD_LOAD = 8'h4C;  // 'L'
   localparam logic [DATA_SZ-1:0] CMD_CONT = 8'h43;  // 'C'
   localparam logic [DATA_SZ-1:0] CMD_STEP = 8'h53;  // 'S'

   // PC + 32 registers + 32 data-memory words
   localparam int          DUMP_WORDS = 65;
   localparam logic [6:0]  DUMP_LAST  = 7'(DUMP_WORDS - 1);

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_LOAD_RX,
      ST_LOAD_WR,
      ST_RUN,
      ST_STEP,
      ST_DUMP_ADDR,
      ST_DUMP_LATCH,
      ST_DUMP_TX,
      ST_DUMP_WAIT
   } state_t;

   // Index 0 is the PC (address unused, 0), 1..32 the register file,
   // 33..64 the data memory.
   function automatic logic [REG_SZ-1:0] dump_addr(input logic [6:0] idx);
      logic [6:0] offs;
      if (idx == 7'd0)
         offs = 7'd0;
      else if (idx <= 7'd32)
         offs = idx - 7'd1;
      else
         offs = idx - 7'd33;
      return offs[REG_SZ-1:0];
   endfunction

endpackage

// File: rtl/pipeline_debug_unit_if.sv
// -----------------------------------------------------------------------------
// pipeline_debug_unit_if
//   Bundle of the debug unit's UART-side and pipeline-side signals.
//   master : the debug unit (drives o_*, reads i_*)
//   slave  : UART + pipeline environment (drives i_*, reads o_*)
//   i_rx_data/i_rx_done  received byte + strobe
//   i_tx_done            transmitter finished last byte
//   i_pc/i_reg/i_mem     pipeline debug read values, i_halt pipeline halted
//   o_tx_data/o_tx_start byte to send + start strobe
//   o_write/o_instruction IF memory write strobe + word
//   o_enable             pipeline execution enable
//   o_debug_addr         debug read address, o_busy unit not idle
// -----------------------------------------------------------------------------
interface pipeline_debug_unit_if
   import pipeline_debug_unit_pkg::*;
();

   logic [DATA_SZ-1:0] i_rx_data;
   logic               i_rx_done;
   logic               i_tx_done;
   logic [INST_SZ-1:0] i_pc;
   logic [INST_SZ-1:0] i_reg;
   logic [INST_SZ-1:0] i_mem;
   logic               i_halt;
   logic [DATA_SZ-1:0] o_tx_data;
   logic               o_tx_start;
   logic               o_write;
   logic [INST_SZ-1:0] o_instruction;
   logic               o_enable;
   logic [REG_SZ-1:0]  o_debug_addr;
   logic               o_busy;

   modport master (
      input  i_rx_data, i_rx_done, i_tx_done, i_pc, i_reg, i_mem, i_halt,
      output o_tx_data, o_tx_start, o_write, o_instruction, o_enable,
             o_debug_addr, o_busy
   );

   modport slave (
      output i_rx_data, i_rx_done, i_tx_done, i_pc, i_reg, i_mem, i_halt,
      input  o_tx_data, o_tx_start, o_write, o_instruction, o_enable,
             o_debug_addr, o_busy
   );

endinterface

// File: rtl/debug_tx_serializer.sv
// -----------------------------------------------------------------------------
// debug_tx_serializer
//   Latches one dump word and presents it MSB byte first on tx_data.
//   clk, srst   clock, synchronous active-high reset
//   load, word  capture word into the shift buffer
//   send        request a transmit strobe for the current byte
//   shift       transmitter finished current byte: advance to next byte
//   tx_data     current byte (top of buffer), stable between shifts
//   tx_start    1-cycle transmit strobe
// -----------------------------------------------------------------------------
module debug_tx_serializer
   import pipeline_debug_unit_pkg::*;
(
   input  logic               clk,
   input  logic               srst,
   input  logic               load,
   input  logic [INST_SZ-1:0] word,
   input  logic               send,
   input  logic               shift,
   output logic [DATA_SZ-1:0] tx_data,
   output logic               tx_start
);

   logic [INST_SZ-1:0] buf_reg;

   always_ff @(posedge clk) begin
      if (srst)
         buf_reg <= '0;
      else if (load)
         buf_reg <= word;
      else if (shift)
         buf_reg <= {buf_reg[INST_SZ-DATA_SZ-1:0], {DATA_SZ{1'b0}}};
   end

   assign tx_data  = buf_reg[INST_SZ-1 -: DATA_SZ];
   assign tx_start = send;

endmodule

// File: rtl/pipeline_debug_unit.sv
// -----------------------------------------------------------------------------
// pipeline_debug_unit
//   Sequencer between a UART byte link and the pipeline: loads programs into
//   IF memory ('L'), runs continuously ('C') or single-steps ('S'), then dumps
//   PC, 32 registers and 32 data words (260 bytes, MSB first) over UART.
//   i_clk    clock
//   i_reset  synchronous active-high reset (aborts any operation)
//   dbg      pipeline_debug_unit_if.master (UART + pipeline signals)
// -----------------------------------------------------------------------------
module pipeline_debug_unit
   import pipeline_debug_unit_pkg::*;
(
   input  logic                        i_clk,
   input  logic                        i_reset,
   pipeline_debug_unit_if.master       dbg
);

   localparam logic [MEM_SZ:0] LAST_WORD = (MEM_SZ+1)'((1 << MEM_SZ) - 1);

   state_t             state_reg, state_next;
   logic [1:0]         byte_cnt_reg;
   logic [MEM_SZ:0]    word_cnt_reg;
   logic [6:0]         idx_reg;
   logic [INST_SZ-1:0] instr_reg;
   logic [REG_SZ-1:0]  addr_reg;
   logic [INST_SZ-1:0] dump_word;
   logic               ser_shift;

   // ---------------- next-state logic ----------------
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE: begin
            if (dbg.i_rx_done) begin
               if (dbg.i_rx_data == CMD_LOAD)      state_next = ST_LOAD_RX;
               else if (dbg.i_rx_data == CMD_CONT) state_next = ST_RUN;
               else if (dbg.i_rx_data == CMD_STEP) state_next = ST_STEP;
            end
         end
         ST_LOAD_RX:
            if (dbg.i_rx_done && byte_cnt_reg == 2'd3) state_next = ST_LOAD_WR;
         ST_LOAD_WR:
            if (instr_reg == HALT_INST || word_cnt_reg == LAST_WORD)
               state_next = ST_IDLE;
            else
               state_next = ST_LOAD_RX;
         ST_RUN:
            if (dbg.i_halt) state_next = ST_DUMP_ADDR;
         ST_STEP:       state_next = ST_DUMP_ADDR;
         ST_DUMP_ADDR:  state_next = ST_DUMP_LATCH;
         ST_DUMP_LATCH: state_next = ST_DUMP_TX;
         ST_DUMP_TX:    state_next = ST_DUMP_WAIT;
         ST_DUMP_WAIT: begin
            if (dbg.i_tx_done) begin
               if (byte_cnt_reg != 2'd3)    state_next = ST_DUMP_TX;
               else if (idx_reg == DUMP_LAST) state_next = ST_IDLE;
               else                         state_next = ST_DUMP_ADDR;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // ---------------- state and datapath registers ----------------
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_reg    <= ST_IDLE;
         byte_cnt_reg <= '0;
         word_cnt_reg <= '0;
         idx_reg      <= '0;
         instr_reg    <= '0;
         addr_reg     <= '0;
      end else begin
         state_reg <= state_next;
         case (state_reg)
            ST_IDLE: begin
               // each command starts its counters from zero
               if (dbg.i_rx_done) begin
                  byte_cnt_reg <= '0;
                  if (dbg.i_rx_data == CMD_LOAD) word_cnt_reg <= '0;
                  if (dbg.i_rx_data == CMD_CONT || dbg.i_rx_data == CMD_STEP)
                     idx_reg <= '0;
               end
            end
            ST_LOAD_RX: begin
               if (dbg.i_rx_done) begin
                  instr_reg    <= {instr_reg[INST_SZ-DATA_SZ-1:0], dbg.i_rx_data};
                  byte_cnt_reg <= byte_cnt_reg + 2'd1;
               end
            end
            ST_LOAD_WR:   word_cnt_reg <= word_cnt_reg + 1'b1;
            ST_DUMP_ADDR: addr_reg     <= dump_addr(idx_reg);
            ST_DUMP_WAIT: begin
               if (dbg.i_tx_done) begin
                  byte_cnt_reg <= byte_cnt_reg + 2'd1;
                  if (byte_cnt_reg == 2'd3 && idx_reg != DUMP_LAST)
                     idx_reg <= idx_reg + 7'd1;
               end
            end
            default: ;
         endcase
      end
   end

   // word selected by the dump index; the address has settled for a cycle
   // by the time DUMP_LATCH captures it
   always_comb begin
      dump_word = dbg.i_mem;
      if (idx_reg == 7'd0)       dump_word = dbg.i_pc;
      else if (idx_reg <= 7'd32) dump_word = dbg.i_reg;
   end

   assign ser_shift = (state_reg == ST_DUMP_WAIT) && dbg.i_tx_done;

   debug_tx_serializer u_ser (
      .clk      (i_clk),
      .srst     (i_reset),
      .load     (state_reg == ST_DUMP_LATCH),
      .word     (dump_word),
      .send     (state_reg == ST_DUMP_TX),
      .shift    (ser_shift),
      .tx_data  (dbg.o_tx_data),
      .tx_start (dbg.o_tx_start)
   );

   // enable is gated combinationally so it drops in the very cycle halt rises
   assign dbg.o_enable      = (state_reg == ST_RUN || state_reg == ST_STEP) && !dbg.i_halt;
   assign dbg.o_write       = (state_reg == ST_LOAD_WR);
   assign dbg.o_instruction = instr_reg;
   assign dbg.o_debug_addr  = addr_reg;
   assign dbg.o_busy        = (state_reg != ST_IDLE);

endmodule
